dip_median_filter: RTL and testbench

- 3x3 median (salt-and-pepper) filter on the 8-bit gray stream.
- Sits between the RGB-to-gray stage and the Sobel stage, all on the camera pixel clock.
- Emits exactly one output pixel per input pixel, so downstream frame counters and the SDRAM address range are unchanged.
- Output image is shifted one pixel right and one pixel down. Border pixels are forced to a constant.

---
 rtl/dip_pkg.sv | 35 +++
 rtl/dip_line_buffer.sv | 29 ++
 rtl/dip_median_filter.sv | 169 ++++++++++++++++
 tb/tb_dip_median_filter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dip_pkg.sv
// Shared types and small combinational helpers for the 3x3 median filter datapath.
package dip_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    pix_t t;
    t = (a < b) ? a : b;
    return (t < c) ? t : c;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t t;
    t = (a > b) ? a : b;
    return (t > c) ? t : c;
  endfunction

  // max(min(a,b), min(max(a,b),c)) is the middle value of three.
  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    pix_t lo;
    pix_t hi;
    pix_t hc;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    hc = (hi < c) ? hi : c;
    return (lo > hc) ? lo : hc;
  endfunction

  function automatic logic [15:0] gray_to_rgb565(input pix_t g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

endpackage

// File: rtl/dip_line_buffer.sv
// Simple dual-port line buffer: one write port, one registered read port returning old data on collision.
module dip_line_buffer
  import dip_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  pix_t mem [2**AW];
  pix_t rd_data_q;

  // NOTE: the RAM array has no reset; clearing it would turn it into a flop bank.
  // Stale contents are harmless because the border rule masks the first two rows.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dip_median_filter.sv
// 3x3 median filter on the gray pixel stream: two line buffers, a sliding window and a
// four-clock sort network; output is shifted one pixel right/down with borders forced constant.
module dip_median_filter
  import dip_pkg::*;
#(
  parameter logic [15:0] CNT_COL_MAX = 16'd1023,
  parameter logic [15:0] CNT_ROW_MAX = 16'd767,
  parameter int          COL_AW      = 10,
  parameter pix_t        BORDER_VAL  = 8'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dip_en,
  input  logic [PIX_W-1:0] dip_data,
  output logic             sdram_wr_en,
  output logic [15:0]      sdram_wr_data,
  output logic [PIX_W-1:0] med_data
);

  // S0
  pix_t        pix_q, pix_d;
  logic        v0_q, v0_d;
  // S1
  logic [15:0] col_cnt_q, col_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;
  pix_t        win_q [3][3];
  pix_t        win_d [3][3];
  logic        v1_q, v1_d, brd1_q, brd1_d;
  // S2
  pix_t        rmin_q [3], rmin_d [3];
  pix_t        rmed_q [3], rmed_d [3];
  pix_t        rmax_q [3], rmax_d [3];
  logic        v2_q, v2_d, brd2_q, brd2_d;
  // S3
  pix_t        lo_q, lo_d, mid_q, mid_d, hi_q, hi_d;
  logic        v3_q, v3_d, brd3_q, brd3_d;
  // S4
  pix_t        med_q, med_d;
  logic [15:0] rgb_q, rgb_d;
  logic        wr_en_q, wr_en_d;

  pix_t        lb0_rd, lb1_rd;
  logic        lb_we;
  logic [COL_AW-1:0] lb_rd_addr, lb_wr_addr;
  pix_t        m;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch); comb logic uses blocking '=', flops use '<='.
  always_comb begin
    pix_d     = dip_en ? dip_data : pix_q;
    v0_d      = dip_en;

    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    win_d     = win_q;
    brd1_d    = brd1_q;
    v1_d      = v0_q;
    if (v0_q) begin
      if (col_cnt_q == CNT_COL_MAX) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == CNT_ROW_MAX) ? '0 : row_cnt_q + 16'd1;
      end else begin
        col_cnt_d = col_cnt_q + 16'd1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_q;
      brd1_d      = (row_cnt_q < 16'd2) || (col_cnt_q < 16'd2);
    end

    // The pixel entering S0 lands in the column after any S1 advance happening this clock.
    lb_rd_addr = col_cnt_d[COL_AW-1:0];
    lb_wr_addr = col_cnt_q[COL_AW-1:0];
    lb_we      = v0_q & ~rst;

    for (int r = 0; r < 3; r++) begin
      rmin_d[r] = min3(win_q[r][0], win_q[r][1], win_q[r][2]);
      rmed_d[r] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
      rmax_d[r] = max3(win_q[r][0], win_q[r][1], win_q[r][2]);
    end
    v2_d   = v1_q;
    brd2_d = brd1_q;

    lo_d   = max3(rmin_q[0], rmin_q[1], rmin_q[2]);
    mid_d  = med3(rmed_q[0], rmed_q[1], rmed_q[2]);
    hi_d   = min3(rmax_q[0], rmax_q[1], rmax_q[2]);
    v3_d   = v2_q;
    brd3_d = brd2_q;

    m       = brd3_q ? BORDER_VAL : med3(lo_q, mid_q, hi_q);
    med_d   = v3_q ? m : med_q;
    rgb_d   = v3_q ? gray_to_rgb565(m) : rgb_q;
    wr_en_d = v3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q     <= '0;
      v0_q      <= 1'b0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      win_q     <= '{default: '0};
      v1_q      <= 1'b0;
      brd1_q    <= 1'b0;
      rmin_q    <= '{default: '0};
      rmed_q    <= '{default: '0};
      rmax_q    <= '{default: '0};
      v2_q      <= 1'b0;
      brd2_q    <= 1'b0;
      lo_q      <= '0;
      mid_q     <= '0;
      hi_q      <= '0;
      v3_q      <= 1'b0;
      brd3_q    <= 1'b0;
      med_q     <= '0;
      rgb_q     <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      v0_q      <= v0_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      win_q     <= win_d;
      v1_q      <= v1_d;
      brd1_q    <= brd1_d;
      rmin_q    <= rmin_d;
      rmed_q    <= rmed_d;
      rmax_q    <= rmax_d;
      v2_q      <= v2_d;
      brd2_q    <= brd2_d;
      lo_q      <= lo_d;
      mid_q     <= mid_d;
      hi_q      <= hi_d;
      v3_q      <= v3_d;
      brd3_q    <= brd3_d;
      med_q     <= med_d;
      rgb_q     <= rgb_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // lb0 holds row r-1; lb1 holds row r-2 and is refilled from lb0's old word.
  dip_line_buffer #(.AW(COL_AW)) u_lb0 (
    .clk     (clk),
    .we      (lb_we),
    .wr_addr (lb_wr_addr),
    .wr_data (pix_q),
    .rd_addr (lb_rd_addr),
    .rd_data (lb0_rd)
  );

  dip_line_buffer #(.AW(COL_AW)) u_lb1 (
    .clk     (clk),
    .we      (lb_we),
    .wr_addr (lb_wr_addr),
    .wr_data (lb0_rd),
    .rd_addr (lb_rd_addr),
    .rd_data (lb1_rd)
  );

  assign sdram_wr_en   = wr_en_q;
  assign sdram_wr_data = rgb_q;
  assign med_data      = med_q;

endmodule

// File: tb/tb_dip_median_filter.sv
// Scoreboard bench for dip_median_filter on an 8x6 frame: a reference 9-value sort predicts each output.
module tb_dip_median_filter;

  localparam int NCOL = 8;
  localparam int NROW = 6;

  logic        clk;
  logic        rst;
  logic        dip_en;
  logic [7:0]  dip_data;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;
  logic [7:0]  med_data;

  typedef struct {
    int         cyc;
    logic [7:0] med;
    bit         ord;
  } exp_t;

  exp_t exp_q[$];
  int   img [NROW][NCOL];
  int   cyc;
  int   m_row;
  int   m_col;
  int   test_id;
  int   checks;
  int   errors;
  logic [7:0]  last_med;
  logic [15:0] last_rgb;

  dip_median_filter #(
    .CNT_COL_MAX (16'd7),
    .CNT_ROW_MAX (16'd5),
    .COL_AW      (3),
    .BORDER_VAL  (8'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dip_en        (dip_en),
    .dip_data      (dip_data),
    .sdram_wr_en   (sdram_wr_en),
    .sdram_wr_data (sdram_wr_data),
    .med_data      (med_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_rgb(input logic [7:0] g);
    logic [15:0] v;
    v = 16'(g >> 3) << 11;
    v = v | (16'(g >> 2) << 5);
    v = v | 16'(g >> 3);
    return v;
  endfunction

  function automatic logic [7:0] ref_median(input int r, input int c);
    int v [9];
    int t;
    int k;
    k = 0;
    for (int i = r - 2; i <= r; i++)
      for (int j = c - 2; j <= c; j++) begin
        v[k] = img[i][j];
        k++;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return 8'(v[4]);
  endfunction

  // Model on the sampling edge, comparison 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_row = 0;
      m_col = 0;
    end else if (dip_en) begin
      img[m_row][m_col] = int'(dip_data);
      e.cyc = cyc;
      e.ord = (test_id == 4) && (m_row == 4) && (m_col == 5);
      e.med = (m_row < 2 || m_col < 2) ? 8'd0 : ref_median(m_row, m_col);
      exp_q.push_back(e);
      if (m_col == NCOL - 1) begin
        m_col = 0;
        m_row = (m_row == NROW - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    #1;
    if (rst) begin
      last_med = 8'd0;
      last_rgb = 16'd0;
    end
    if (sdram_wr_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("latency", 32'(cyc - e.cyc), 32'd4);
        check("med_data", 32'(med_data), 32'(e.med));
        check("sdram_wr_data", 32'(sdram_wr_data), 32'(ref_rgb(e.med)));
        if (e.ord) check("ord_4_5", 32'(med_data), 32'd34);
        last_med = e.med;
        last_rgb = ref_rgb(e.med);
      end
    end else begin
      check("hold_med", 32'(med_data), 32'(last_med));
      check("hold_rgb", 32'(sdram_wr_data), 32'(last_rgb));
    end
  end

  task automatic send(input logic [7:0] v, input int gap);
    dip_en   = 1'b1;
    dip_data = v;
    @(negedge clk);
    if (gap > 1) begin
      dip_en = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    dip_en = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    test_id  = 0;
    last_med = 8'd0;
    last_rgb = 16'd0;
    rst      = 1'b1;
    dip_en   = 1'b0;
    dip_data = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_wr_en", 32'(sdram_wr_en), 32'd0);
    check("rst_med", 32'(med_data), 32'd0);
    check("rst_rgb", 32'(sdram_wr_data), 32'd0);
    check("rst_col", 32'(dut.col_cnt_q), 32'd0);

    test_id = 1;
    for (int i = 0; i < NROW * NCOL; i++) send(8'h80, 1);
    drain();
    check("const_rgb", 32'(sdram_wr_data), 32'h8410);

    test_id = 2;
    for (int i = 0; i < NROW * NCOL; i++) send(8'h80, (i < 24) ? 2 : 3);
    drain();

    test_id = 3;
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        send((r == 3 && c == 3) ? 8'hFF : 8'h10, 1);
    drain();

    test_id = 4;
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        send(8'(10 * r + c), 1);
    drain();

    test_id = 5;
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), 1);
    rst      = 1'b1;
    dip_en   = 1'b1;
    dip_data = 8'hFF;
    @(negedge clk);
    rst    = 1'b0;
    dip_en = 1'b0;
    check("midrst_col", 32'(dut.col_cnt_q), 32'd0);
    check("midrst_row", 32'(dut.row_cnt_q), 32'd0);
    for (int i = 0; i < NROW * NCOL; i++)
      send(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
    drain();

    test_id = 6;
    for (int i = 0; i < 2 * NROW * NCOL; i++) send(8'($urandom_range(0, 255)), 1);
    drain();
    check("wrap_col", 32'(dut.col_cnt_q), 32'd0);
    check("wrap_row", 32'(dut.row_cnt_q), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
